// File: rtl/write_addr_channel_decoder_if.sv
// AXI4 write-address channel bundle.
// The master modport drives the payload and awvalid; the slave modport returns awready.
interface write_addr_channel_decoder_if #(
    parameter int Address_width  = 32,
    parameter int Slaves_ID_Size = 1,
    parameter int S00_Aw_len     = 8
);
    logic [Address_width-1:0]  awaddr;
    logic [Slaves_ID_Size-1:0] awaddr_ID;
    logic [S00_Aw_len-1:0]     awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic [1:0]                awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic [3:0]                awqos;
    logic                      awvalid;
    logic                      awready;

    modport master (
        output awaddr, awaddr_ID, awlen, awsize,
        output awburst, awlock, awcache, awprot,
        output awqos, awvalid,
        input  awready
    );

    modport slave (
        input  awaddr, awaddr_ID, awlen, awsize,
        input  awburst, awlock, awcache, awprot,
        input  awqos, awvalid,
        output awready
    );
endinterface

// File: rtl/write_addr_channel_decoder.sv
// AW channel decoder: routes one master AW channel to M00/M01 by address region.
// The route is pinned while a request waits, so a changing awaddr cannot steer it away.
module write_addr_channel_decoder #(
    parameter int Address_width   = 32,
    parameter int Base_Addr_Width = 2,
    parameter int Slaves_Num      = 2,
    parameter int Slaves_ID_Size  = $clog2(Slaves_Num),
    parameter int S00_Aw_len      = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    write_addr_channel_decoder_if.slave  Master_AXI,
    write_addr_channel_decoder_if.master M00_AXI,
    write_addr_channel_decoder_if.master M01_AXI,
    output logic [Slaves_Num-1:0]       Q_Enables,
    output logic                        Sel_Slave_Ready
);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_e;

    state_e                    state_q, state_d;
    logic [Slaves_ID_Size-1:0] locked_sel_q, locked_sel_d;
    logic [Slaves_ID_Size-1:0] dec_sel;
    logic [Slaves_ID_Size-1:0] sel;
    logic [Base_Addr_Width-1:0] region;
    logic [Slaves_Num-1:0]     rdy_vec;
    logic [Slaves_Num-1:0]     sel_oh;
    logic                      sel_rdy;
    logic                      vld;

    assign vld     = Master_AXI.awvalid;
    assign region  = Master_AXI.awaddr[Address_width-1 -: Base_Addr_Width];
    assign dec_sel = Slaves_ID_Size'(int'(region) % Slaves_Num);
    assign rdy_vec = {M01_AXI.awready, M00_AXI.awready};

    // A dropped awvalid releases the pinned route in the same cycle.
    always_comb begin
        sel = dec_sel;
        if (state_q == ST_LOCKED && vld) begin
            sel = locked_sel_q;
        end
    end

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = ARESETN;
    end

    assign sel_rdy   = |(rdy_vec & sel_oh);
    assign Q_Enables = rdy_vec & sel_oh & {Slaves_Num{vld}};

    assign Sel_Slave_Ready   = sel_rdy;
    assign Master_AXI.awready = sel_rdy;

    assign M00_AXI.awvalid = vld & sel_oh[0];
    assign M01_AXI.awvalid = vld & sel_oh[1];

    assign M00_AXI.awaddr    = Master_AXI.awaddr;
    assign M00_AXI.awaddr_ID = Master_AXI.awaddr_ID;
    assign M00_AXI.awlen     = Master_AXI.awlen;
    assign M00_AXI.awsize    = Master_AXI.awsize;
    assign M00_AXI.awburst   = Master_AXI.awburst;
    assign M00_AXI.awlock    = Master_AXI.awlock;
    assign M00_AXI.awcache   = Master_AXI.awcache;
    assign M00_AXI.awprot    = Master_AXI.awprot;
    assign M00_AXI.awqos     = Master_AXI.awqos;

    assign M01_AXI.awaddr    = Master_AXI.awaddr;
    assign M01_AXI.awaddr_ID = Master_AXI.awaddr_ID;
    assign M01_AXI.awlen     = Master_AXI.awlen;
    assign M01_AXI.awsize    = Master_AXI.awsize;
    assign M01_AXI.awburst   = Master_AXI.awburst;
    assign M01_AXI.awlock    = Master_AXI.awlock;
    assign M01_AXI.awcache   = Master_AXI.awcache;
    assign M01_AXI.awprot    = Master_AXI.awprot;
    assign M01_AXI.awqos     = Master_AXI.awqos;

    always_comb begin
        state_d      = state_q;
        locked_sel_d = locked_sel_q;
        unique case (state_q)
            ST_OPEN: begin
                if (vld && !sel_rdy) begin
                    state_d      = ST_LOCKED;
                    locked_sel_d = sel;
                end
            end
            ST_LOCKED: begin
                if (!vld || sel_rdy) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= ST_OPEN;
            locked_sel_q <= '0;
        end else begin
            state_q      <= state_d;
            locked_sel_q <= locked_sel_d;
        end
    end

endmodule

// File: tb/tb_write_addr_channel_decoder.sv
// Bench for write_addr_channel_decoder: directed cases plus random traffic,
// expected responses queued by a reference model and checked by a monitor.
module tb_write_addr_channel_decoder;

    logic ACLK;
    logic ARESETN;
    logic [1:0] Q_Enables;
    logic Sel_Slave_Ready;

    write_addr_channel_decoder_if #(.Slaves_ID_Size(1)) m_if ();
    write_addr_channel_decoder_if #(.Slaves_ID_Size(1)) s0_if ();
    write_addr_channel_decoder_if #(.Slaves_ID_Size(1)) s1_if ();

    write_addr_channel_decoder dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .Master_AXI      (m_if),
        .M00_AXI         (s0_if),
        .M01_AXI         (s1_if),
        .Q_Enables       (Q_Enables),
        .Sel_Slave_Ready (Sel_Slave_Ready)
    );

    typedef struct {
        logic        m0v;
        logic        m1v;
        logic        mrdy;
        logic        ssr;
        logic [1:0]  q;
        logic [58:0] pay;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_err;
    int   pending;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [58:0] pay_m();
        return {m_if.awaddr, m_if.awaddr_ID, m_if.awlen, m_if.awsize,
                m_if.awburst, m_if.awlock, m_if.awcache, m_if.awprot,
                m_if.awqos};
    endfunction

    function automatic int model_sel(input logic [31:0] a, input logic v);
        if (pending >= 0 && v) return pending;
        return int'(a >> 30) % 2;
    endfunction

    task automatic drive_cycle(input logic [31:0] a, input logic v,
                               input logic r0, input logic r1,
                               input logic [7:0] len,
                               input logic [1:0] burst);
        exp_t e;
        int   s;
        logic rdy;
        @(negedge ACLK);
        m_if.awaddr    = a;
        m_if.awvalid   = v;
        m_if.awlen     = len;
        m_if.awburst   = burst;
        m_if.awaddr_ID = 1'($urandom);
        m_if.awsize    = 3'($urandom);
        m_if.awlock    = 2'($urandom);
        m_if.awcache   = 4'($urandom);
        m_if.awprot    = 3'($urandom);
        m_if.awqos     = 4'($urandom);
        s0_if.awready  = r0;
        s1_if.awready  = r1;
        #1;
        s      = model_sel(a, v);
        rdy    = (s == 0) ? r0 : r1;
        e.m0v  = ARESETN && v && s == 0;
        e.m1v  = ARESETN && v && s == 1;
        e.ssr  = ARESETN && rdy;
        e.mrdy = e.ssr;
        e.q    = (ARESETN && v && rdy) ? 2'(1 << s) : 2'b00;
        e.pay  = pay_m();
        exp_q.push_back(e);
        @(posedge ACLK);
        if (!ARESETN) pending = -1;
        else if (v && !rdy) pending = s;
        else pending = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m0v"}, 64'(s0_if.awvalid), 64'd0);
        chk({tag, "_m1v"}, 64'(s1_if.awvalid), 64'd0);
        chk({tag, "_q"}, 64'(Q_Enables), 64'd0);
        chk({tag, "_mrdy"}, 64'(m_if.awready), 64'd0);
        chk({tag, "_ssr"}, 64'(Sel_Slave_Ready), 64'd0);
    endtask

    initial begin
        exp_t e;
        logic [58:0] p0, p1;
        forever begin
            @(negedge ACLK);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                p0 = {s0_if.awaddr, s0_if.awaddr_ID, s0_if.awlen,
                      s0_if.awsize, s0_if.awburst, s0_if.awlock,
                      s0_if.awcache, s0_if.awprot, s0_if.awqos};
                p1 = {s1_if.awaddr, s1_if.awaddr_ID, s1_if.awlen,
                      s1_if.awsize, s1_if.awburst, s1_if.awlock,
                      s1_if.awcache, s1_if.awprot, s1_if.awqos};
                chk("m00_awvalid", 64'(s0_if.awvalid), 64'(e.m0v));
                chk("m01_awvalid", 64'(s1_if.awvalid), 64'(e.m1v));
                chk("q_enables", 64'(Q_Enables), 64'(e.q));
                chk("master_awready", 64'(m_if.awready), 64'(e.mrdy));
                chk("sel_slave_ready", 64'(Sel_Slave_Ready), 64'(e.ssr));
                chk("m00_payload", 64'(p0), 64'(e.pay));
                chk("m01_payload", 64'(p1), 64'(e.pay));
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        pending = -1;
        ARESETN = 1'b0;
        m_if.awaddr    = 32'h0000_1000;
        m_if.awaddr_ID = '0;
        m_if.awlen     = '0;
        m_if.awsize    = '0;
        m_if.awburst   = '0;
        m_if.awlock    = '0;
        m_if.awcache   = '0;
        m_if.awprot    = '0;
        m_if.awqos     = '0;
        m_if.awvalid   = 1'b1;
        s0_if.awready  = 1'b1;
        s1_if.awready  = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        chk_reset_outputs("reset");
        #1;
        ARESETN = 1'b1;

        drive_cycle(32'h0000_1000, 1, 1, 1, 8'h00, 2'b01);
        drive_cycle(32'h4000_1000, 1, 1, 1, 8'h00, 2'b01);
        drive_cycle(32'h8000_0000, 1, 1, 1, 8'h0F, 2'b01);
        drive_cycle(32'hC000_0000, 1, 1, 1, 8'h0F, 2'b01);
        drive_cycle(32'h4000_0000, 0, 1, 0, 8'h0F, 2'b01);

        drive_cycle(32'h0000_0000, 1, 0, 1, 8'h03, 2'b01);
        drive_cycle(32'h4000_0000, 1, 0, 1, 8'h03, 2'b01);
        drive_cycle(32'h4000_0000, 1, 0, 1, 8'h03, 2'b01);
        drive_cycle(32'h4000_0000, 1, 1, 1, 8'h03, 2'b01);
        drive_cycle(32'h4000_0000, 1, 1, 1, 8'h03, 2'b01);

        drive_cycle(32'h0000_0000, 1, 0, 1, 8'h01, 2'b00);
        drive_cycle(32'h4000_0000, 0, 0, 1, 8'h01, 2'b00);
        drive_cycle(32'h4000_0000, 1, 0, 1, 8'h01, 2'b00);

        drive_cycle(32'h0000_0000, 1, 0, 1, 8'h07, 2'b01);
        #2;
        ARESETN = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        pending = -1;
        drive_cycle(32'h4000_0000, 1, 1, 1, 8'h07, 2'b01);
        #2;
        ARESETN = 1'b1;
        drive_cycle(32'h4000_0000, 1, 0, 1, 8'h07, 2'b01);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            drive_cycle(a, ($urandom_range(0, 9) < 7),
                        ($urandom_range(0, 2) != 0),
                        ($urandom_range(0, 2) != 0),
                        8'($urandom), 2'($urandom));
        end

        repeat (3) @(posedge ACLK);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
